// File: rtl/mux8_pkg.sv
// Shared constants and helpers for the 8-to-1 decoder-driven multiplexer.
//
// Contents:
//   N_IN       - number of input lanes (fixed at 8)
//   SEL_W      - select width, log2(N_IN)
//   onehot_dec - maps a SEL_W-bit select to an N_IN-bit one-hot vector
package mux8_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = $clog2(N_IN);

  // Built from equality compares rather than a case statement so that an
  // unknown select yields unknown decoder bits in simulation instead of
  // silently falling into a default branch.
  function automatic logic [N_IN-1:0] onehot_dec(input logic [SEL_W-1:0] sel);
    logic [N_IN-1:0] dec;
    dec = '0;
    for (int k = 0; k < N_IN; k++) begin
      dec[k] = (sel == SEL_W'(k));
    end
    return dec;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 line decoder, purely combinational.
//
// Ports:
//   s - 3-bit select
//   d - 8-bit one-hot output, d[k] = 1 iff s == k
module dec3to8
  import mux8_pkg::*;
(
  input  logic [SEL_W-1:0] s,
  output logic [N_IN-1:0]  d
);

  assign d = onehot_dec(s);

endmodule

// File: rtl/mux8_dec_tsb.sv
// 8-to-1 multiplexer: a 3-to-8 decoder gates eight lanes onto one shared
// bus, and the bus value is registered.
//
// The "tristate" bus is modelled as an AND-OR structure: each lane is
// masked by its decoder bit and all masked lanes are ORed together. The
// decoder is one-hot, so at most one lane contributes at any time.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - synchronous active-low reset, priority over en
//   en      - capture enable
//   s       - lane select
//   I       - packed lanes, lane k = I[k*WIDTH +: WIDTH]
//   y       - registered selected lane
//   sel_oh  - registered one-hot decoder value that produced y
//   y_valid - high the cycle after an en=1 capture
module mux8_dec_tsb
  import mux8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [SEL_W-1:0]      s,
  input  logic [N_IN*WIDTH-1:0] I,
  output logic [WIDTH-1:0]      y,
  output logic [N_IN-1:0]       sel_oh,
  output logic                  y_valid
);

  logic [N_IN-1:0]  dec;
  logic [WIDTH-1:0] lane_drive [N_IN];
  logic [WIDTH-1:0] bus_value;

  logic [WIDTH-1:0] y_reg;
  logic [N_IN-1:0]  sel_oh_reg;
  logic             y_valid_reg;

  dec3to8 u_dec (
    .s (s),
    .d (dec)
  );

  // Each lane only drives when its decoder bit is set.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_drive
    assign lane_drive[gi] = I[gi*WIDTH +: WIDTH] & {WIDTH{dec[gi]}};
  end

  // Wired-OR of all drivers; one-hot select means no contention.
  always_comb begin
    bus_value = '0;
    for (int k = 0; k < N_IN; k++) begin
      bus_value = bus_value | lane_drive[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg       <= '0;
      sel_oh_reg  <= '0;
      y_valid_reg <= 1'b0;
    end else if (en) begin
      y_reg       <= bus_value;
      sel_oh_reg  <= dec;
      y_valid_reg <= 1'b1;
    end else begin
      y_valid_reg <= 1'b0;
    end
  end

  assign y       = y_reg;
  assign sel_oh  = sel_oh_reg;
  assign y_valid = y_valid_reg;

endmodule

// File: tb/tb_mux8_dec_tsb.sv
// Directed self-checking bench for mux8_dec_tsb (WIDTH=1).
// Inputs change 1 time unit after a rising edge; outputs are checked at
// the same point, after the edge that captured them.
module tb_mux8_dec_tsb;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] s;
  logic [7:0] I;
  logic [0:0] y;
  logic [7:0] sel_oh;
  logic       y_valid;

  int tests_run;
  int tests_failed;

  mux8_dec_tsb #(.WIDTH(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .s       (s),
    .I       (I),
    .y       (y),
    .sel_oh  (sel_oh),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic chk_all(input string tag, input logic exp_y, input logic [7:0] exp_oh,
                         input logic exp_v);
    chk({tag, ".y"}, {7'd0, y}, {7'd0, exp_y});
    chk({tag, ".sel_oh"}, sel_oh, exp_oh);
    chk({tag, ".y_valid"}, {7'd0, y_valid}, {7'd0, exp_v});
    $display("[TB] %s s=%0d I=%h en=%0b -> y=%0b sel_oh=%h y_valid=%0b",
             tag, s, I, en, y, sel_oh, y_valid);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset held for two cycles while en=1 tries to capture lane 3.
    rst_n = 1'b0; en = 1'b1; s = 3'd3; I = 8'hFF;
    tick();
    tick();
    chk_all("reset", 1'b0, 8'h00, 1'b0);

    rst_n = 1'b1;
    tick();
    chk_all("first_capture", 1'b1, 8'h08, 1'b1);

    // Exhaustive select sweep with all-zero then all-one lanes.
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      I = 8'h00;
      tick();
      chk_all($sformatf("sweep0_s%0d", k), 1'b0, 8'h01 << k, 1'b1);
      I = 8'hFF;
      tick();
      chk_all($sformatf("sweep1_s%0d", k), 1'b1, 8'h01 << k, 1'b1);
    end

    // Walking one across all 64 lane/select combinations.
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) begin
        I = 8'h01 << j;
        s = 3'(k);
        tick();
        chk_all($sformatf("walk_j%0d_s%0d", j, k), (j == k) ? 1'b1 : 1'b0,
                8'h01 << k, 1'b1);
      end
    end

    // Enable hold: outputs freeze while en=0 even though lanes change.
    s = 3'd5; I = 8'h20; en = 1'b1;
    tick();
    chk_all("hold_capture", 1'b1, 8'h20, 1'b1);
    en = 1'b0; I = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_all($sformatf("hold_c%0d", c), 1'b1, 8'h20, 1'b0);
    end

    // Reset in the middle of operation wins over en.
    en = 1'b1; s = 3'd5; I = 8'h20;
    tick();
    chk_all("mid_pre", 1'b1, 8'h20, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_all("mid_reset", 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1; s = 3'd2; I = 8'h04;
    tick();
    chk_all("mid_resume", 1'b1, 8'h04, 1'b1);

    // Back-to-back select changes: y follows s with one cycle of lag.
    I = 8'h80;
    for (int c = 0; c < 6; c++) begin
      s = (c % 2 == 1) ? 3'd7 : 3'd0;
      tick();
      chk_all($sformatf("alt_c%0d", c), (c % 2 == 1) ? 1'b1 : 1'b0,
              (c % 2 == 1) ? 8'h80 : 8'h01, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
